// File: rtl/soft_rst_pkg.sv
// Shared types for the software reset sequencer: FSM states and err_stage codes.
package soft_rst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        ASSERT,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_QUIESCE   = 2'd1;
    localparam logic [1:0] ERR_WAIT_LOW  = 2'd2;
    localparam logic [1:0] ERR_WAIT_HIGH = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sig_sync_2ff.sv
// Single-bit two-flop synchronizer; both flops reset to 0.
module sig_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soft_reset_ctrl.sv
// Software reset sequencer: quiesce masters, pulse the generator's external reset,
// then confirm its aresetn outputs fall and rise again. Runs on power-on reset only.
module soft_reset_ctrl
    import soft_rst_pkg::*;
#(
    parameter int PULSE_CYC           = 16,
    parameter int QUIESCE_TO          = 1024,
    parameter int RST_TO              = 4096,
    parameter int EXT_RST_ACTIVE_HIGH = 0
) (
    input  logic       slowest_sync_clk,
    input  logic       por_aresetn,
    input  logic       soft_rst_req,
    output logic       quiesce_req,
    input  logic       quiesce_ack,
    output logic       ext_reset_out,
    input  logic       peripheral_aresetn,
    input  logic       interconnect_aresetn,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic [1:0] err_stage
);

    localparam int CW = $clog2(max3(QUIESCE_TO, RST_TO, PULSE_CYC)) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] Q_LAST  = CW'(QUIESCE_TO - 1);
    localparam logic [CW-1:0] P_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] R_LAST  = CW'(RST_TO - 1);
    localparam logic EXT_ON = (EXT_RST_ACTIVE_HIGH != 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          seen_low, seen_n;
    logic          err_to_n;
    logic [1:0]    err_st_n;
    logic          per_s, icn_s;

    sig_sync_2ff u_sync_per (
        .clk   (slowest_sync_clk),
        .rst_n (por_aresetn),
        .d     (peripheral_aresetn),
        .q     (per_s)
    );

    sig_sync_2ff u_sync_icn (
        .clk   (slowest_sync_clk),
        .rst_n (por_aresetn),
        .d     (interconnect_aresetn),
        .q     (icn_s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt_inc;
        seen_n   = seen_low;
        err_to_n = err_timeout;
        err_st_n = err_stage;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (soft_rst_req) begin
                    state_n  = QUIESCE;
                    cnt_n    = '0;
                    err_to_n = 1'b0;
                    err_st_n = ERR_NONE;
                end
            end
            QUIESCE: begin
                if (quiesce_ack || cnt == Q_LAST) begin
                    // Timeout still forces the reset; the error is just recorded.
                    if (!quiesce_ack) begin
                        err_to_n = 1'b1;
                        if (!err_timeout) err_st_n = ERR_QUIESCE;
                    end
                    state_n = ASSERT;
                    cnt_n   = '0;
                    seen_n  = 1'b0;
                end
            end
            ASSERT: begin
                seen_n = seen_low | ~per_s | ~icn_s;
                if (cnt == P_LAST) begin
                    state_n = seen_n ? WAIT_HIGH : WAIT_LOW;
                    cnt_n   = '0;
                end
            end
            WAIT_LOW: begin
                if (!per_s || !icn_s) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = '0;
                end else if (cnt == R_LAST) begin
                    state_n  = DONE;
                    err_to_n = 1'b1;
                    if (!err_timeout) err_st_n = ERR_WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                if (per_s && icn_s) begin
                    state_n = DONE;
                end else if (cnt == R_LAST) begin
                    state_n  = DONE;
                    err_to_n = 1'b1;
                    if (!err_timeout) err_st_n = ERR_WAIT_HIGH;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = cnt;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered off the next state so they line up with the state register.
    always_ff @(posedge slowest_sync_clk or negedge por_aresetn) begin
        if (!por_aresetn) begin
            state         <= IDLE;
            cnt           <= '0;
            seen_low      <= 1'b0;
            quiesce_req   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ext_reset_out <= ~EXT_ON;
            err_timeout   <= 1'b0;
            err_stage     <= ERR_NONE;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            seen_low      <= seen_n;
            quiesce_req   <= (state_n != IDLE);
            busy          <= (state_n != IDLE);
            done          <= (state_n == DONE);
            ext_reset_out <= (state_n == ASSERT) ? EXT_ON : ~EXT_ON;
            err_timeout   <= err_to_n;
            err_stage     <= err_st_n;
        end
    end

endmodule

// File: tb/tb_soft_reset_ctrl.sv
// Scoreboard bench for soft_reset_ctrl: directed sequences push expected completion
// records; a negedge monitor measures each sequence and compares on every done pulse.
module tb_soft_reset_ctrl;

    typedef struct {
        int et;
        int es;
        int qw;
        int pl;
        int pl1;
        int gap;
    } rec_t;

    logic clk, por, req, ack, per_n, icn_n;
    logic qreq0, ext0, busy0, done0, err0;
    logic qreq1, ext1, busy1, done1, err1;
    logic [1:0] stage0, stage1;

    int n_checks = 0;
    int n_err    = 0;
    int ndone    = 0;
    int gen_mode = 0;
    rec_t exp_q[$];

    soft_reset_ctrl dut0 (
        .slowest_sync_clk     (clk),
        .por_aresetn          (por),
        .soft_rst_req         (req),
        .quiesce_req          (qreq0),
        .quiesce_ack          (ack),
        .ext_reset_out        (ext0),
        .peripheral_aresetn   (per_n),
        .interconnect_aresetn (icn_n),
        .busy                 (busy0),
        .done                 (done0),
        .err_timeout          (err0),
        .err_stage            (stage0)
    );

    soft_reset_ctrl #(.EXT_RST_ACTIVE_HIGH(1)) dut1 (
        .slowest_sync_clk     (clk),
        .por_aresetn          (por),
        .soft_rst_req         (req),
        .quiesce_req          (qreq1),
        .quiesce_ack          (ack),
        .ext_reset_out        (ext1),
        .peripheral_aresetn   (per_n),
        .interconnect_aresetn (icn_n),
        .busy                 (busy1),
        .done                 (done1),
        .err_timeout          (err1),
        .err_stage            (stage1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Generator model: mode 0 drops aresetn 3 cycles into the pulse and releases it
    // 20 cycles after deassert (interconnect one cycle later); 1 stuck high; 2 stuck low.
    initial begin
        int a_cnt, d_cnt;
        a_cnt = 0;
        d_cnt = 0;
        forever begin
            @(negedge clk);
            icn_n = per_n;
            case (gen_mode)
                0: begin
                    if (ext0 == 1'b0) begin
                        d_cnt = 0;
                        a_cnt++;
                        if (a_cnt == 3) per_n = 1'b0;
                    end else begin
                        a_cnt = 0;
                        if (per_n == 1'b0) begin
                            d_cnt++;
                            if (d_cnt == 20) begin
                                per_n = 1'b1;
                                d_cnt = 0;
                            end
                        end
                    end
                end
                1: per_n = 1'b1;
                default: begin
                    per_n = 1'b0;
                    icn_n = 1'b0;
                end
            endcase
        end
    end

    // Monitor: qw = cycles busy before the pulse, pl/pl1 = pulse widths of each
    // instance, gap = cycles from pulse end to done.
    initial begin
        int qw, pl, pl1, gap;
        bit chk_busy;
        rec_t e;
        qw = 0; pl = 0; pl1 = 0; gap = 0; chk_busy = 0;
        forever begin
            @(negedge clk);
            if (!por) begin
                qw = 0; pl = 0; pl1 = 0; gap = 0; chk_busy = 0;
            end else begin
                if (chk_busy) begin
                    chk_busy = 0;
                    chk("busy_after_done", busy0, 0);
                end
                if (ext0 == 1'b0) pl++;
                if (ext1 == 1'b1) pl1++;
                if (busy0 && pl == 0 && ext0) qw++;
                if (pl > 0 && ext0 && !done0) gap++;
                if (done0) begin
                    ndone++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("err_timeout", err0, e.et);
                        chk("err_stage", stage0, e.es);
                        chk("quiesce_cycles", qw, e.qw);
                        chk("pulse_len", pl, e.pl);
                        chk("pulse_len_hi", pl1, e.pl1);
                        chk("done_gap", gap, e.gap);
                    end
                    qw = 0; pl = 0; pl1 = 0; gap = 0; chk_busy = 1;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk("seq_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // d: ack delay in cycles (0 = already high with the request, <0 = never).
    task automatic run_seq(input int d, input rec_t e, input bit extra);
        exp_q.push_back(e);
        req = 1'b1;
        if (d == 0) ack = 1'b1;
        @(negedge clk);
        req = 1'b0;
        if (d > 0) begin
            repeat (d - 1) @(negedge clk);
            ack = 1'b1;
        end
        if (extra) begin
            repeat (3) @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            repeat (5) @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        wait_done(6000);
        ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        por = 1'b0; req = 1'b0; ack = 1'b0; per_n = 1'b1; icn_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_quiesce_req", qreq0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err_timeout", err0, 0);
        chk("rst_err_stage", stage0, 0);
        chk("rst_ext_lo", ext0, 1);
        chk("rst_ext_hi", ext1, 0);
        por = 1'b1;
        repeat (5) @(negedge clk);

        run_seq(5, '{0, 0, 5, 16, 16, 23}, 1'b0);
        run_seq(-1, '{1, 1, 1024, 16, 16, 23}, 1'b0);
        gen_mode = 1;
        run_seq(0, '{1, 2, 1, 16, 16, 4096}, 1'b0);
        gen_mode = 2;
        repeat (5) @(negedge clk);
        run_seq(0, '{1, 3, 1, 16, 16, 4096}, 1'b0);
        gen_mode = 0;
        repeat (30) @(negedge clk);
        chk("err_persist_timeout", err0, 1);
        chk("err_persist_stage", stage0, 3);

        run_seq(5, '{0, 0, 5, 16, 16, 23}, 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_req_single_seq", busy0, 0);
        chk("done_count", ndone, 5);

        // Power-on reset in the middle of the pulse.
        req = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_por_ext_lo", ext0, 0);
        chk("pre_por_ext_hi", ext1, 1);
        #2 por = 1'b0;
        #1;
        chk("por_quiesce_req", qreq0, 0);
        chk("por_busy", busy0, 0);
        chk("por_done", done0, 0);
        chk("por_err_timeout", err0, 0);
        chk("por_err_stage", stage0, 0);
        chk("por_ext_lo", ext0, 1);
        chk("por_ext_hi", ext1, 0);
        @(negedge clk);
        por = 1'b1;
        ack = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_por_idle", busy0, 0);
        chk("post_por_done_count", ndone, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/soft_reset_ctrl.md
# soft_reset_ctrl

Software-initiated reset sequencer that drives the external reset input of the processor-system reset generator and watches its outputs until the reset cycle completes. It quiesces bus masters first, asserts a reset pulse of a guaranteed minimum width, and confirms that the generated `peripheral_aresetn`/`interconnect_aresetn` went low and then returned high. It reports done and timeout status to the register block. It runs on the power-on reset only, never on the resets it causes.

## Interface
- `PULSE_CYC`, 16: cycles the external reset is held asserted; legal range 4..255.
- `QUIESCE_TO`, 1024: maximum cycles to wait for `quiesce_ack`.
- `RST_TO`, 4096: maximum cycles to wait in each of `WAIT_LOW` and `WAIT_HIGH`.
- `EXT_RST_ACTIVE_HIGH`, 0: polarity of `ext_reset_out`; 0 means active-low.

Ports:
- `slowest_sync_clk`  in  1  sole clock.
- `por_aresetn`  in  1  asynchronous, active-low power-on reset.
- `soft_rst_req`  in  1  request; sampled only in `IDLE`.
- `quiesce_req`  out  1  asks bus masters to drain; held high from `QUIESCE` through `DONE`.
- `quiesce_ack`  in  1  masters idle; synchronous to `slowest_sync_clk`.
- `ext_reset_out`  out  1  drives the generator's external reset input.
- `peripheral_aresetn`  in  1  generator output; asynchronous, passes through a 2-flop synchronizer.
- `interconnect_aresetn`  in  1  generator output; asynchronous, passes through a 2-flop synchronizer.
- `busy`  out  1  high in every state except `IDLE`.
- `done`  out  1  one-cycle pulse at the end of each sequence.
- `err_timeout`  out  1  sticky; cleared when a new request is accepted.
- `err_stage`  out  2  stage of the first timeout: 0 none, 1 quiesce, 2 wait-low, 3 wait-high.

## Operation
- States: `IDLE`, `QUIESCE`, `ASSERT`, `WAIT_LOW`, `WAIT_HIGH`, `DONE`.
- **IDLE**
  - `soft_rst_req`=1 moves to `QUIESCE`.
  - Acceptance clears `err_timeout` and `err_stage` and loads `cnt`=0.
- **QUIESCE**
  - `quiesce_ack`=1 moves to `ASSERT`.
  - `cnt`==`QUIESCE_TO`-1 also moves to `ASSERT`, and sets `err_timeout`=1 and `err_stage`=1. The reset is forced anyway.
- **ASSERT**
  - `ext_reset_out` is asserted for exactly `PULSE_CYC` cycles.
  - Flag `seen_low` is set if either synchronized aresetn is 0 during the pulse.
  - At the end of the pulse: go to `WAIT_HIGH` if `seen_low`, otherwise to `WAIT_LOW`. `cnt` reloads to 0.
- **WAIT_LOW**
  - Either synchronized aresetn = 0 moves to `WAIT_HIGH`.
  - Timeout at `RST_TO`: set error, `err_stage`=2, go to `DONE`.
- **WAIT_HIGH**
  - Both synchronized aresetn = 1 moves to `DONE`.
  - Timeout at `RST_TO`: set error, `err_stage`=3, go to `DONE`.
- **DONE**
  - `done`=1 for one cycle, then go to `IDLE`.
  - `quiesce_req` and `busy` fall on entry to `IDLE`.
- Error rules:
  - Only the first timeout in a sequence writes `err_stage`.
  - `err_timeout` and `err_stage` persist through `IDLE`.
- Request rules:
  - `soft_rst_req` while `busy` is ignored, not queued.
  - Holding `soft_rst_req` high starts a new sequence on the cycle after `DONE`.
- `cnt`:
  - Width is `$clog2(max(QUIESCE_TO,RST_TO,PULSE_CYC))+1`.
  - It saturates and never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - `quiesce_req`=0, `busy`=0, `done`=0, `err_timeout`=0, `err_stage`=0.
  - `ext_reset_out` = its deasserted level, i.e. `~EXT_RST_ACTIVE_HIGH`.
  - State = `IDLE`, synchronizer flops = 0.
- Request to `quiesce_req`/`busy` high: 1 cycle.
- `quiesce_ack` to `ext_reset_out` asserted: 1 cycle.
- aresetn edge to internal visibility: 2 cycles (synchronizer), plus 1 cycle for the state change.
- `por_aresetn` low mid-sequence:
  - Immediate asynchronous return to reset values.
  - A truncated pulse is acceptable because power-on reset covers the downstream logic.

## Structure
- Package `soft_rst_pkg`:
  - State enum.
  - `err_stage` codes `ERR_NONE`, `ERR_QUIESCE`, `ERR_WAIT_LOW`, `ERR_WAIT_HIGH`.
- Sub-module `sig_sync_2ff`: a single-bit two-flop synchronizer with reset value 0. It is instantiated once for each aresetn input.
- Top level holds the FSM, `cnt` and `seen_low`.

## Test plan
- **Nominal.** Defaults. Pulse `soft_rst_req`, `quiesce_ack` high 5 cycles later, model generator drops aresetn 3 cycles after assert and releases it 20 cycles after deassert:
  - `ext_reset_out`=0 for exactly 16 cycles.
  - `done` pulses once.
  - `err_timeout`=0, `busy` falls on the cycle after `done`.
- **Quiesce timeout.** `quiesce_ack` stuck 0:
  - `ext_reset_out` asserts 1024 cycles after entering `QUIESCE`.
  - `err_timeout`=1, `err_stage`=1, sequence completes with `done`.
- **Generator dead.** aresetn stuck 1:
  - After the pulse, `done` comes 4096 cycles later.
  - `err_stage`=2.
- **Stuck in reset.** aresetn stuck 0 → `err_stage`=3 after 4096 cycles in `WAIT_HIGH`.
- **Busy request and power-on reset.**
  - Request pulses while `busy` → exactly one sequence runs.
  - `por_aresetn` low during `ASSERT` → all outputs take their reset values immediately, including `ext_reset_out`=1.
- **Polarity.** `EXT_RST_ACTIVE_HIGH`=1 → pulse is high, reset level is 0.
